// File: rtl/dma_ch_sched.sv
// dma_ch_sched: per-channel length tracking, burst splitting and
// round-robin grant of one in-flight burst to the SGDMA TLP engine.
module dma_ch_sched #(
  parameter int NUM_CH  = 2,
  parameter int LEN_W   = 24,
  parameter int TIMEOUT = 4096
) (
  input  logic                    wb_clk_i,
  input  logic                    wb_rst_n_i,
  input  logic [NUM_CH-1:0]       ch_start,
  input  logic [NUM_CH*LEN_W-1:0] ch_len,
  input  logic [11:0]             max_payload,
  input  logic                    abort,
  input  logic [NUM_CH-1:0]       dma_req,
  input  logic                    burst_done,
  output logic [NUM_CH-1:0]       dma_ack,
  output logic [1:0]              active_ch,
  output logic [15:0]             burst_len,
  output logic                    enable,
  output logic [NUM_CH-1:0]       ch_busy,
  output logic [NUM_CH-1:0]       ch_done,
  output logic                    err
);

  localparam int IW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (LEN_W > 16) ? LEN_W : 16;
  localparam int WW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    BURST
  } state_t;

  state_t            state;
  logic [LEN_W-1:0]  rem [NUM_CH];
  logic [IW-1:0]     rr;
  logic [IW-1:0]     idx;
  logic [IW-1:0]     pick;
  logic [IW-1:0]     c;
  logic              found;
  logic [WW-1:0]     wd;
  logic [NUM_CH-1:0] elig;
  logic [CW-1:0]     rem_cur;
  logic [CW-1:0]     mp_ext;
  logic [CW-1:0]     blen;
  logic [CW-1:0]     rem_nxt;

  assign elig = ch_busy & dma_req;

  // First eligible channel at or after the round-robin pointer.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    c     = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      c = IW'((32'(rr) + k) % NUM_CH);
      if (!found && elig[c]) begin
        found = 1'b1;
        pick  = c;
      end
    end
  end

  // Burst size for the latched channel and its post-burst remainder.
  always_comb begin
    rem_cur = CW'(rem[idx]);
    mp_ext  = CW'(max_payload);
    blen    = (rem_cur < mp_ext) ? rem_cur : mp_ext;
    rem_nxt = rem_cur - CW'(burst_len);
  end

  // Channel bookkeeping, grant FSM and watchdog.
  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state     <= IDLE;
      rr        <= '0;
      idx       <= '0;
      wd        <= '0;
      dma_ack   <= '0;
      active_ch <= '0;
      burst_len <= '0;
      enable    <= 1'b0;
      ch_busy   <= '0;
      ch_done   <= '0;
      err       <= 1'b0;
      for (int i = 0; i < NUM_CH; i++)
        rem[i] <= '0;
    end else begin
      ch_done <= '0;
      err     <= 1'b0;
      if (abort) begin
        state     <= IDLE;
        dma_ack   <= '0;
        enable    <= 1'b0;
        burst_len <= '0;
        ch_busy   <= '0;
        for (int i = 0; i < NUM_CH; i++)
          rem[i] <= '0;
      end else begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (ch_start[i] && !ch_busy[i]) begin
            if (ch_len[i*LEN_W +: LEN_W] == '0) begin
              ch_done[i] <= 1'b1;
            end else begin
              rem[i]     <= ch_len[i*LEN_W +: LEN_W];
              ch_busy[i] <= 1'b1;
            end
          end
        end
        unique case (state)
          IDLE: begin
            if (found) begin
              idx   <= pick;
              state <= GRANT;
            end
          end
          GRANT: begin
            burst_len <= blen[15:0];
            active_ch <= 2'(idx);
            dma_ack   <= NUM_CH'(1) << idx;
            enable    <= 1'b1;
            wd        <= '0;
            state     <= BURST;
          end
          BURST: begin
            if (burst_done) begin
              dma_ack  <= '0;
              enable   <= 1'b0;
              rem[idx] <= rem_nxt[LEN_W-1:0];
              rr       <= (idx == IW'(NUM_CH - 1)) ? '0 : idx + 1'b1;
              if (rem_nxt == '0) begin
                ch_busy[idx] <= 1'b0;
                ch_done[idx] <= 1'b1;
              end
              state <= IDLE;
            end else if (wd == WW'(TIMEOUT - 1)) begin
              err          <= 1'b1;
              ch_busy[idx] <= 1'b0;
              rem[idx]     <= '0;
              dma_ack      <= '0;
              enable       <= 1'b0;
              state        <= IDLE;
            end else begin
              wd <= wd + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dma_ch_sched.sv
// tb_dma_ch_sched: directed scenarios for the DMA channel scheduler,
// hand-computed expectations, one task per scenario.
module tb_dma_ch_sched;

  localparam int NUM_CH  = 2;
  localparam int LEN_W   = 24;
  localparam int TIMEOUT = 16;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic [NUM_CH-1:0]       ch_start = '0;
  logic [NUM_CH*LEN_W-1:0] ch_len = '0;
  logic [11:0]             max_payload = 12'd128;
  logic                    abort = 1'b0;
  logic [NUM_CH-1:0]       dma_req = '0;
  logic                    burst_done = 1'b0;
  logic [NUM_CH-1:0]       dma_ack;
  logic [1:0]              active_ch;
  logic [15:0]             burst_len;
  logic                    enable;
  logic [NUM_CH-1:0]       ch_busy;
  logic [NUM_CH-1:0]       ch_done;
  logic                    err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dma_ch_sched #(
    .NUM_CH (NUM_CH),
    .LEN_W  (LEN_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .ch_start   (ch_start),
    .ch_len     (ch_len),
    .max_payload(max_payload),
    .abort      (abort),
    .dma_req    (dma_req),
    .burst_done (burst_done),
    .dma_ack    (dma_ack),
    .active_ch  (active_ch),
    .burst_len  (burst_len),
    .enable     (enable),
    .ch_busy    (ch_busy),
    .ch_done    (ch_done),
    .err        (err)
  );

  task tick;
    @(posedge clk);
    #1;
  endtask

  task do_reset;
    rst_n       = 1'b0;
    ch_start    = '0;
    ch_len      = '0;
    max_payload = 12'd128;
    abort       = 1'b0;
    dma_req     = '0;
    burst_done  = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
  endtask

  task wait_ack(input int bound, output int n, output bit got);
    got = 1'b0;
    n   = 0;
    for (int i = 1; i <= bound && !got; i++) begin
      tick;
      if (dma_ack != '0) begin
        got = 1'b1;
        n   = i;
      end
    end
  endtask

  task pulse_done;
    burst_done = 1'b1;
    tick;
    burst_done = 1'b0;
  endtask

  task test_reset;
    rst_n = 1'b0;
    tick;
    checks++;
    if ({dma_ack, active_ch, burst_len, enable, ch_busy, ch_done, err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs ack=%b ch=%0d len=%0d en=%b busy=%b done=%b err=%b required all zero",
               dma_ack, active_ch, burst_len, enable, ch_busy, ch_done, err);
    end
    rst_n = 1'b1;
    tick;
    checks++;
    if (dma_ack !== '0 || enable !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle ack=%b en=%b required 00/0", dma_ack, enable);
    end
  endtask

  task test_single;
    int n;
    bit got;
    logic [1:0] exp_done;
    logic [1:0] exp_busy;
    do_reset;
    ch_len[0 +: LEN_W] = 24'd512;
    ch_start = 2'b01;
    tick;
    ch_start = '0;
    checks++;
    if (ch_busy !== 2'b01) begin
      errors++;
      $display("FAIL t1_busy got=%b required 01", ch_busy);
    end
    dma_req = 2'b01;
    for (int b = 0; b < 4; b++) begin
      exp_done = (b == 3) ? 2'b01 : 2'b00;
      exp_busy = (b == 3) ? 2'b00 : 2'b01;
      wait_ack(8, n, got);
      checks++;
      if (!got || n != 2) begin
        errors++;
        $display("FAIL t1_latency burst=%0d got=%0d cycles=%0d required 2", b, got, n);
      end
      checks++;
      if (dma_ack !== 2'b01 || active_ch !== 2'd0 || burst_len !== 16'd128 || enable !== 1'b1) begin
        errors++;
        $display("FAIL t1_grant burst=%0d ack=%b ch=%0d len=%0d en=%b required 01/0/128/1",
                 b, dma_ack, active_ch, burst_len, enable);
      end
      repeat (9) tick;
      checks++;
      if (dma_ack !== 2'b01 || burst_len !== 16'd128) begin
        errors++;
        $display("FAIL t1_hold burst=%0d ack=%b len=%0d required 01/128", b, dma_ack, burst_len);
      end
      pulse_done;
      checks++;
      if (dma_ack !== '0 || enable !== 1'b0 || ch_done !== exp_done || ch_busy !== exp_busy) begin
        errors++;
        $display("FAIL t1_done burst=%0d ack=%b en=%b done=%b busy=%b required 00/0/%b/%b",
                 b, dma_ack, enable, ch_done, ch_busy, exp_done, exp_busy);
      end
    end
    tick;
    checks++;
    if (ch_done !== 2'b00) begin
      errors++;
      $display("FAIL t1_done_pulse got=%b required 00", ch_done);
    end
    dma_req = '0;
  endtask

  task test_round_robin;
    int n;
    bit got;
    logic [1:0]  exp_ch [3];
    logic [15:0] exp_len [3];
    logic [1:0]  exp_done [3];
    exp_ch   = '{2'd0, 2'd1, 2'd0};
    exp_len  = '{16'd128, 16'd64, 16'd72};
    exp_done = '{2'b00, 2'b10, 2'b01};
    do_reset;
    ch_len[0 +: LEN_W]     = 24'd200;
    ch_len[LEN_W +: LEN_W] = 24'd64;
    ch_start = 2'b11;
    tick;
    ch_start = '0;
    dma_req  = 2'b11;
    for (int b = 0; b < 3; b++) begin
      wait_ack(8, n, got);
      checks++;
      if (!got || active_ch !== exp_ch[b] || burst_len !== exp_len[b] ||
          dma_ack !== (2'b01 << exp_ch[b])) begin
        errors++;
        $display("FAIL t2_grant burst=%0d got=%0d ch=%0d len=%0d ack=%b required ch=%0d len=%0d",
                 b, got, active_ch, burst_len, dma_ack, exp_ch[b], exp_len[b]);
      end
      repeat (3) tick;
      pulse_done;
      checks++;
      if (ch_done !== exp_done[b]) begin
        errors++;
        $display("FAIL t2_done burst=%0d got=%b required %b", b, ch_done, exp_done[b]);
      end
    end
    checks++;
    if (ch_busy !== 2'b00) begin
      errors++;
      $display("FAIL t2_busy got=%b required 00", ch_busy);
    end
    dma_req = '0;
  endtask

  task test_zero_len;
    bit bad;
    do_reset;
    ch_len[LEN_W +: LEN_W] = 24'd0;
    ch_start = 2'b10;
    dma_req  = 2'b11;
    tick;
    ch_start = '0;
    checks++;
    if (ch_done !== 2'b10 || ch_busy !== 2'b00) begin
      errors++;
      $display("FAIL t3_done done=%b busy=%b required 10/00", ch_done, ch_busy);
    end
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick;
      if (dma_ack !== 2'b00 || ch_done !== 2'b00)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL t3_no_grant ack=%b done=%b required 00/00", dma_ack, ch_done);
    end
    dma_req = '0;
  endtask

  task test_watchdog;
    int n;
    bit got;
    bit bad;
    do_reset;
    ch_len[0 +: LEN_W] = 24'd512;
    ch_start = 2'b01;
    tick;
    ch_start = '0;
    dma_req  = 2'b01;
    wait_ack(8, n, got);
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL t4_ack got=0 required 1");
    end
    n   = 0;
    got = 1'b0;
    for (int i = 1; i <= 40 && !got; i++) begin
      tick;
      if (err === 1'b1) begin
        got = 1'b1;
        n   = i;
      end
    end
    checks++;
    if (!got || n != 16) begin
      errors++;
      $display("FAIL t4_err_time got=%0d cycles=%0d required 16", got, n);
    end
    checks++;
    if (ch_busy !== 2'b00 || dma_ack !== 2'b00 || enable !== 1'b0 || ch_done !== 2'b00) begin
      errors++;
      $display("FAIL t4_drop busy=%b ack=%b en=%b done=%b required 00/00/0/00",
               ch_busy, dma_ack, enable, ch_done);
    end
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick;
      if (err !== 1'b0 || dma_ack !== 2'b00)
        bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL t4_idle err=%b ack=%b required 0/00", err, dma_ack);
    end
    dma_req = '0;
  endtask

  task test_abort;
    int n;
    bit got;
    bit bad;
    do_reset;
    ch_len[0 +: LEN_W]     = 24'd512;
    ch_len[LEN_W +: LEN_W] = 24'd512;
    ch_start = 2'b11;
    tick;
    ch_start = '0;
    dma_req  = 2'b11;
    wait_ack(8, n, got);
    checks++;
    if (!got || dma_ack !== 2'b01) begin
      errors++;
      $display("FAIL t5_ack got=%0d ack=%b required 01", got, dma_ack);
    end
    repeat (3) tick;
    abort    = 1'b1;
    ch_start = 2'b11;
    tick;
    abort    = 1'b0;
    ch_start = '0;
    checks++;
    if ({dma_ack, burst_len, enable, ch_busy, ch_done, err} !== '0) begin
      errors++;
      $display("FAIL t5_abort ack=%b len=%0d en=%b busy=%b done=%b err=%b required all zero",
               dma_ack, burst_len, enable, ch_busy, ch_done, err);
    end
    pulse_done;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (ch_done !== 2'b00 || dma_ack !== 2'b00 || err !== 1'b0)
        bad = 1'b1;
      tick;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL t5_after done=%b ack=%b err=%b required 00/00/0", ch_done, dma_ack, err);
    end
    dma_req = '0;
  endtask

  task test_async_reset;
    int n;
    bit got;
    do_reset;
    ch_len[0 +: LEN_W] = 24'd256;
    ch_start = 2'b01;
    tick;
    ch_start = '0;
    dma_req  = 2'b01;
    wait_ack(8, n, got);
    repeat (2) tick;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({dma_ack, active_ch, burst_len, enable, ch_busy, ch_done, err} !== '0) begin
      errors++;
      $display("FAIL t6_async ack=%b len=%0d en=%b busy=%b required all zero",
               dma_ack, burst_len, enable, ch_busy);
    end
    tick;
    rst_n = 1'b1;
    tick;
    ch_len[0 +: LEN_W] = 24'd128;
    ch_start = 2'b01;
    tick;
    ch_start = '0;
    wait_ack(8, n, got);
    checks++;
    if (!got || n != 2 || burst_len !== 16'd128 || dma_ack !== 2'b01) begin
      errors++;
      $display("FAIL t6_restart got=%0d cycles=%0d len=%0d ack=%b required 1/2/128/01",
               got, n, burst_len, dma_ack);
    end
    repeat (2) tick;
    pulse_done;
    checks++;
    if (ch_done !== 2'b01 || ch_busy !== 2'b00) begin
      errors++;
      $display("FAIL t6_done done=%b busy=%b required 01/00", ch_done, ch_busy);
    end
    dma_req = '0;
  endtask

  initial begin
    test_reset;
    test_single;
    test_round_robin;
    test_zero_len;
    test_watchdog;
    test_abort;
    test_async_reset;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
